// File: rtl/lz_norm_pipe_if.sv
// Stream interface for lz_norm_pipe: input beat (mantissa/exponent/tag) and normalised output beat.
// master drives beats in and accepts results; slave is the normaliser itself.
interface lz_norm_pipe_if #(
  parameter int WIDTH = 24,
  parameter int EXP_W = 8,
  parameter int TAG_W = 4
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_mant;
  logic [EXP_W-1:0] in_exp;
  logic [TAG_W-1:0] in_tag;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_mant;
  logic [EXP_W-1:0] out_exp;
  logic [CNT_W-1:0] out_lz;
  logic             out_zero;
  logic             out_uflow;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_mant, in_exp, in_tag, out_ready,
    input  in_ready, out_valid, out_mant, out_exp, out_lz, out_zero, out_uflow, out_tag
  );

  modport slave (
    input  in_valid, in_mant, in_exp, in_tag, out_ready,
    output in_ready, out_valid, out_mant, out_exp, out_lz, out_zero, out_uflow, out_tag
  );
endinterface

// File: rtl/lz_norm_pipe.sv
// Two-stage leading-zero counter and mantissa normaliser with full valid/ready backpressure.
// Optional macro LZN_DENORM_CLAMP_EN clamps the shift so small exponents produce denormals.
module lz_norm_pipe #(
  parameter int WIDTH = 24,
  parameter int EXP_W = 8,
  parameter int TAG_W = 4
) (
  input logic           clk,
  input logic           rst_n,
  lz_norm_pipe_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int SUB_W = ((EXP_W > CNT_W) ? EXP_W : CNT_W) + 1;

  logic             r_s1Valid;
  logic [WIDTH-1:0] r_s1Mant;
  logic [EXP_W-1:0] r_s1Exp;
  logic [TAG_W-1:0] r_s1Tag;
  logic [CNT_W-1:0] r_s1Lz;
  logic             r_s1Zero;

  logic             r_s2Valid;
  logic [WIDTH-1:0] r_s2Mant;
  logic [EXP_W-1:0] r_s2Exp;
  logic [TAG_W-1:0] r_s2Tag;
  logic [CNT_W-1:0] r_s2Lz;
  logic             r_s2Zero;
  logic             r_s2Uflow;

  logic             w_s1Adv;
  logic             w_s2Adv;
  logic [CNT_W-1:0] w_lz;
  logic             w_zero;
  logic [SUB_W-1:0] w_diff;
  logic             w_uflowCase;
  logic [CNT_W-1:0] w_shift;
  logic [WIDTH-1:0] w_mant;

  assign w_s2Adv      = !r_s2Valid || bus.out_ready;
  assign w_s1Adv      = !r_s1Valid || w_s2Adv;
  assign bus.in_ready = w_s1Adv;

  // Ascending scan: the highest set bit is the last to write, so it wins.
  always_comb begin
    w_lz = CNT_W'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (bus.in_mant[i]) w_lz = CNT_W'(WIDTH - 1 - i);
    end
  end

  assign w_zero = (bus.in_mant == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1Valid <= 1'b0;
      r_s1Mant  <= '0;
      r_s1Exp   <= '0;
      r_s1Tag   <= '0;
      r_s1Lz    <= '0;
      r_s1Zero  <= 1'b0;
    end else if (w_s1Adv) begin
      r_s1Valid <= bus.in_valid;
      if (bus.in_valid) begin
        r_s1Mant <= bus.in_mant;
        r_s1Exp  <= bus.in_exp;
        r_s1Tag  <= bus.in_tag;
        r_s1Lz   <= w_lz;
        r_s1Zero <= w_zero;
      end
    end
  end

  // A borrow or an exact zero difference means the exponent cannot absorb the shift.
  assign w_diff      = SUB_W'(r_s1Exp) - SUB_W'(r_s1Lz);
  assign w_uflowCase = w_diff[SUB_W-1] || (w_diff == '0);

`ifdef LZN_DENORM_CLAMP_EN
  always_comb begin
    w_shift = r_s1Lz;
    if (w_uflowCase) begin
      w_shift = (r_s1Exp == '0) ? '0 : CNT_W'(r_s1Exp - EXP_W'(1));
    end
  end
`else
  assign w_shift = r_s1Lz;
`endif

  assign w_mant = r_s1Mant << w_shift;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2Valid <= 1'b0;
      r_s2Mant  <= '0;
      r_s2Exp   <= '0;
      r_s2Tag   <= '0;
      r_s2Lz    <= '0;
      r_s2Zero  <= 1'b0;
      r_s2Uflow <= 1'b0;
    end else if (w_s2Adv) begin
      r_s2Valid <= r_s1Valid;
      if (r_s1Valid) begin
        r_s2Mant  <= r_s1Zero ? '0 : w_mant;
        r_s2Exp   <= (r_s1Zero || w_uflowCase) ? '0 : w_diff[EXP_W-1:0];
        r_s2Tag   <= r_s1Tag;
        r_s2Lz    <= r_s1Lz;
        r_s2Zero  <= r_s1Zero;
        r_s2Uflow <= w_uflowCase && !r_s1Zero;
      end
    end
  end

  assign bus.out_valid = r_s2Valid;
  assign bus.out_mant  = r_s2Mant;
  assign bus.out_exp   = r_s2Exp;
  assign bus.out_lz    = r_s2Lz;
  assign bus.out_zero  = r_s2Zero;
  assign bus.out_uflow = r_s2Uflow;
  assign bus.out_tag   = r_s2Tag;
endmodule

// File: tb/tb_lz_norm_pipe.sv
// Self-checking bench for lz_norm_pipe: directed and random beats against an arithmetic reference model.
// Build with LZN_DENORM_CLAMP_EN defined to check the denormal-clamp variant.
module tb_lz_norm_pipe;
  localparam int W = 24;
  localparam int E = 8;
  localparam int T = 4;

  typedef struct {
    logic [W-1:0] mant;
    logic [E-1:0] exp;
    int           lz;
    bit           zero;
    bit           uflow;
    logic [T-1:0] tag;
    int           acc;
  } beat_t;

  logic  clk = 1'b0;
  logic  rst_n;
  int    checks = 0;
  int    errors = 0;
  int    cycle = 0;
  int    lastPop = -10;
  beat_t q[$];

  lz_norm_pipe_if #(.WIDTH(W), .EXP_W(E), .TAG_W(T)) bus ();

  lz_norm_pipe #(.WIDTH(W), .EXP_W(E), .TAG_W(T)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference: bit length by repeated halving, shift as multiplication by a power of two.
  function automatic beat_t model(input logic [W-1:0] m, input logic [E-1:0] e, input logic [T-1:0] t);
    beat_t  b;
    longint v;
    longint p;
    int     len;
    int     sh;
    int     ie;
    v   = longint'(m);
    len = 0;
    while (v > 0) begin
      v = v / 2;
      len++;
    end
    ie     = int'(e);
    b.lz   = W - len;
    b.tag  = t;
    b.acc  = 0;
    b.zero = (m == '0);
    sh     = b.lz;
    if (b.zero) begin
      b.exp   = '0;
      b.uflow = 1'b0;
    end else if (ie > b.lz) begin
      b.exp   = E'(ie - b.lz);
      b.uflow = 1'b0;
    end else begin
      b.exp   = '0;
      b.uflow = 1'b1;
`ifdef LZN_DENORM_CLAMP_EN
      sh = (ie == 0) ? 0 : ie - 1;
`endif
    end
    p      = longint'(m) * (longint'(1) << sh);
    b.mant = W'(p);
    return b;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // The head beat becomes visible two cycles after acceptance or one cycle after the previous pop.
  task automatic checkOutput();
    bit    due;
    beat_t h;
    int    vis;
    check("in_ready", 32'(bus.in_ready), 32'((q.size() < 2) || bus.out_ready));
    due = 1'b0;
    if (q.size() > 0) begin
      h   = q[0];
      vis = (h.acc + 2 > lastPop + 1) ? h.acc + 2 : lastPop + 1;
      due = (cycle >= vis);
    end
    check("out_valid", 32'(bus.out_valid), 32'(due));
    if (due && bus.out_valid === 1'b1) begin
      check("out_mant",  32'(bus.out_mant),  32'(h.mant));
      check("out_exp",   32'(bus.out_exp),   32'(h.exp));
      check("out_lz",    32'(bus.out_lz),    32'(h.lz));
      check("out_zero",  32'(bus.out_zero),  32'(h.zero));
      check("out_uflow", 32'(bus.out_uflow), 32'(h.uflow));
      check("out_tag",   32'(bus.out_tag),   32'(h.tag));
      if (bus.out_ready) begin
        void'(q.pop_front());
        lastPop = cycle;
      end
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [W-1:0] m, input logic [E-1:0] e,
                               input logic [T-1:0] t, input logic r, output logic acc);
    beat_t b;
    @(negedge clk);
    bus.in_valid  = v;
    bus.in_mant   = m;
    bus.in_exp    = e;
    bus.in_tag    = t;
    bus.out_ready = r;
    #1;
    checkOutput();
    acc = v && (bus.in_ready === 1'b1);
    if (acc) begin
      b     = model(m, e, t);
      b.acc = cycle;
      q.push_back(b);
    end
    cycle++;
  endtask

  task automatic doReset();
    @(negedge clk);
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 32'(0));
    check("rst_out_mant",  32'(bus.out_mant),  32'(0));
    check("rst_out_exp",   32'(bus.out_exp),   32'(0));
    check("rst_out_lz",    32'(bus.out_lz),    32'(0));
    check("rst_out_tag",   32'(bus.out_tag),   32'(0));
    check("rst_out_flags", 32'({bus.out_zero, bus.out_uflow}), 32'(0));
    q.delete();
    cycle++;
    @(negedge clk);
    #1;
    check("rst_hold_valid", 32'(bus.out_valid), 32'(0));
    rst_n = 1'b1;
    cycle++;
  endtask

  task automatic drain();
    logic a;
    for (int i = 0; i < 12; i++) applyStimulus(1'b0, '0, '0, '0, 1'b1, a);
    check("drain_empty", 32'(q.size()), 32'(0));
  endtask

  initial begin
    logic         acc;
    int           idx;
    logic [W-1:0] m;
    logic [E-1:0] e;
    logic [W-1:0] bpMant[6];
    logic [E-1:0] bpExp[6];

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_mant   = '0;
    bus.in_exp    = '0;
    bus.in_tag    = '0;
    bus.out_ready = 1'b1;
    doReset();

    applyStimulus(1'b1, 24'h800000, 8'd127, 4'd3, 1'b1, acc);
    drain();
    applyStimulus(1'b1, 24'h000001, 8'd100, 4'd1, 1'b1, acc);
    drain();
    applyStimulus(1'b1, 24'h000000, 8'd50, 4'd2, 1'b1, acc);
    drain();
    applyStimulus(1'b1, 24'h001000, 8'd5, 4'd4, 1'b1, acc);
    drain();
    applyStimulus(1'b1, 24'h400000, 8'd0, 4'd5, 1'b1, acc);
    applyStimulus(1'b1, 24'h000100, 8'd16, 4'd6, 1'b1, acc);
    applyStimulus(1'b1, 24'h000100, 8'd255, 4'd7, 1'b1, acc);
    drain();

    // Six back-to-back beats with the sink stalled for cycles 3..6.
    for (int i = 0; i < 6; i++) begin
      bpMant[i] = W'($urandom) >> $urandom_range(0, 12);
      bpExp[i]  = E'($urandom);
    end
    idx = 0;
    for (int s = 0; s < 16; s++) begin
      applyStimulus(idx < 6, (idx < 6) ? bpMant[idx] : '0, (idx < 6) ? bpExp[idx] : '0,
                    T'(idx), !(s >= 3 && s <= 6), acc);
      if (acc) idx++;
    end
    check("bp_all_sent", 32'(idx), 32'(6));
    drain();

    applyStimulus(1'b1, 24'h123456, 8'd90, 4'd8, 1'b1, acc);
    applyStimulus(1'b1, 24'h000FFF, 8'd9, 4'd9, 1'b1, acc);
    doReset();
    applyStimulus(1'b1, 24'h00ABCD, 8'd200, 4'd10, 1'b1, acc);
    drain();

    for (int s = 0; s < 400; s++) begin
      m = W'($urandom) >> $urandom_range(0, W);
      e = ($urandom_range(0, 1) == 0) ? E'($urandom_range(0, 30)) : E'($urandom);
      applyStimulus($urandom_range(0, 3) != 0, m, e, T'(s), $urandom_range(0, 3) != 0, acc);
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
